// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared CAN definitions for the overload-frame transmitter and the
// error-frame logic that will reuse the same bit counter.
//   ovl_state_t         : overload transmitter state encoding
//   CAN_OVL_*           : default overload frame geometry
//   CAN_MAX_REQ_OVERLOADS : limit on back-to-back request-driven frames
//   CAN_DOMINANT/RECESSIVE: bus levels (1 = recessive)
//   can_sat_inc()       : saturating increment used by all bit counters
// ---------------------------------------------------------------------------
package can_pkg;

    typedef enum logic [1:0] {
        OVL_IDLE     = 2'd0,
        OVL_FLAG     = 2'd1,
        OVL_WAIT_REC = 2'd2,
        OVL_DELIM    = 2'd3
    } ovl_state_t;

    localparam int CAN_OVL_FLAG_BITS     = 6;
    localparam int CAN_OVL_DELIM_BITS    = 8;
    localparam int CAN_OVL_MAX_EXTRA_DOM = 7;
    localparam int CAN_MAX_REQ_OVERLOADS = 2;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    // Width of every bit/frame counter in the CAN block.
    localparam int CAN_CNT_W = 4;

    // Counters stick at all-ones instead of wrapping, so a long run of
    // stuck bus bits can never alias back onto a small threshold.
    function automatic logic [CAN_CNT_W-1:0] can_sat_inc(input logic [CAN_CNT_W-1:0] v);
        logic [CAN_CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CAN_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/can_bit_counter.sv
// ---------------------------------------------------------------------------
// can_bit_counter
// Strobe-enabled saturating counter with synchronous clear and load.
// Only updates on clk edges where en=1 (the bit sample strobe).
// Priority within a strobe: clr > load > inc.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   en         : bit sample strobe
//   clr        : force count to 0
//   load       : load load_val
//   load_val   : value for load
//   inc        : saturating increment
//   count      : current count
// ---------------------------------------------------------------------------
module can_bit_counter
    import can_pkg::*;
#(
    parameter int WIDTH = CAN_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            if (clr) begin
                count_d = '0;
            end else if (load) begin
                count_d = load_val;
            end else if (inc) begin
                if (&count_q) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/overload_frame_tx.sv
// ---------------------------------------------------------------------------
// overload_frame_tx
// Transmits CAN overload frames: FLAG_BITS dominant flag bits, waits out
// superposed flags from other nodes, then DELIM_BITS recessive delimiter
// bits. Starts reactively (isOverload during interframe space) or on a
// local request at intermission start, with at most MAX_REQ_OVERLOADS
// consecutive request-driven frames. endOverload tells the interframe
// monitor to restart intermission tracking.
//   clk, rst_n      : clock, asynchronous active-low reset
//   samplePoint     : one-clk strobe per bit sample point
//   canRX           : bus level (1 = recessive)
//   frameReady      : 1 = interframe space (previous EOF complete)
//   isOverload      : reactive overload condition
//   overloadRequest : local receiver requests a delay (level)
//   canTX           : registered transmit level (1 = recessive)
//   overloadBusy    : frame in progress
//   endOverload     : delimiter complete, held for exactly one bit
//   bitError, formError, flagError : one-clk error pulses
// ---------------------------------------------------------------------------
module overload_frame_tx
    import can_pkg::*;
#(
    parameter int FLAG_BITS         = CAN_OVL_FLAG_BITS,
    parameter int DELIM_BITS        = CAN_OVL_DELIM_BITS,
    parameter int MAX_EXTRA_DOM     = CAN_OVL_MAX_EXTRA_DOM,
    parameter int MAX_REQ_OVERLOADS = CAN_MAX_REQ_OVERLOADS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic samplePoint,
    input  logic canRX,
    input  logic frameReady,
    input  logic isOverload,
    input  logic overloadRequest,
    output logic canTX,
    output logic overloadBusy,
    output logic endOverload,
    output logic bitError,
    output logic formError,
    output logic flagError
);

    localparam logic [CAN_CNT_W-1:0] FLAG_LIM  = CAN_CNT_W'(FLAG_BITS);
    localparam logic [CAN_CNT_W-1:0] DELIM_LIM = CAN_CNT_W'(DELIM_BITS);
    localparam logic [CAN_CNT_W-1:0] EXTRA_LIM = CAN_CNT_W'(MAX_EXTRA_DOM);
    localparam logic [CAN_CNT_W-1:0] REQ_LIM   = CAN_CNT_W'(MAX_REQ_OVERLOADS);

    ovl_state_t state_q, state_d;

    logic can_tx_q, can_tx_d;
    logic end_ovl_q, end_ovl_d;
    logic bit_err_q, bit_err_d;
    logic form_err_q, form_err_d;
    logic flag_err_q, flag_err_d;
    // Set when the next frameReady=1 strobe is an intermission start.
    logic armed_q, armed_d;

    // Bit counter control
    logic                 cnt_clr;
    logic                 cnt_load;
    logic [CAN_CNT_W-1:0] cnt_load_val;
    logic                 cnt_inc;
    logic [CAN_CNT_W-1:0] cnt;
    logic [CAN_CNT_W-1:0] cnt_next;

    // Request-driven frame counter control
    logic                 req_clr;
    logic                 req_inc;
    logic [CAN_CNT_W-1:0] req_count;

    logic intermission_start;
    logic req_allowed;

    can_bit_counter #(
        .WIDTH (CAN_CNT_W)
    ) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (samplePoint),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .count    (cnt)
    );

    can_bit_counter #(
        .WIDTH (CAN_CNT_W)
    ) u_req_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (samplePoint),
        .clr      (req_clr),
        .load     (1'b0),
        .load_val ({CAN_CNT_W{1'b0}}),
        .inc      (req_inc),
        .count    (req_count)
    );

    // Value the bit counter will hold after an increment on this strobe;
    // thresholds are tested against it so the transition happens on the
    // strobe that completes the bit, not one strobe later.
    assign cnt_next           = can_sat_inc(cnt);
    assign intermission_start = frameReady & armed_q;
    assign req_allowed        = overloadRequest & (req_count < REQ_LIM);

    always_comb begin
        state_d      = state_q;
        end_ovl_d    = end_ovl_q;
        armed_d      = armed_q;
        bit_err_d    = 1'b0;
        form_err_d   = 1'b0;
        flag_err_d   = 1'b0;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_inc      = 1'b0;
        req_clr      = 1'b0;
        req_inc      = 1'b0;

        if (samplePoint) begin
            // endOverload covers exactly the one bit after completion.
            end_ovl_d = 1'b0;

            if (!frameReady) begin
                // Leaving interframe space: silent abort of any frame in
                // progress, reset the request budget, re-arm intermission.
                state_d = OVL_IDLE;
                cnt_clr = 1'b1;
                req_clr = 1'b1;
                armed_d = 1'b1;
            end else begin
                // Any frameReady=1 strobe consumes the intermission start.
                armed_d = 1'b0;
                unique case (state_q)
                    OVL_IDLE: begin
                        if (isOverload) begin
                            // Reactive start wins over a simultaneous request
                            // and does not use the request budget.
                            state_d = OVL_FLAG;
                            cnt_clr = 1'b1;
                        end else if (intermission_start && req_allowed) begin
                            state_d = OVL_FLAG;
                            cnt_clr = 1'b1;
                            req_inc = 1'b1;
                        end
                    end

                    OVL_FLAG: begin
                        if (canRX == CAN_DOMINANT) begin
                            cnt_inc = 1'b1;
                            if (cnt_next == FLAG_LIM) begin
                                state_d = OVL_WAIT_REC;
                                cnt_clr = 1'b1;
                            end
                        end else begin
                            // Read back recessive while driving dominant.
                            bit_err_d = 1'b1;
                            state_d   = OVL_IDLE;
                            cnt_clr   = 1'b1;
                        end
                    end

                    OVL_WAIT_REC: begin
                        if (canRX == CAN_DOMINANT) begin
                            cnt_inc = 1'b1;
                            if (cnt_next == EXTRA_LIM) begin
                                flag_err_d = 1'b1;
                                state_d    = OVL_IDLE;
                                cnt_clr    = 1'b1;
                            end
                        end else if (DELIM_LIM == CAN_CNT_W'(1)) begin
                            // Single-bit delimiter: first recessive bit ends it.
                            end_ovl_d = 1'b1;
                            armed_d   = 1'b1;
                            state_d   = OVL_IDLE;
                            cnt_clr   = 1'b1;
                        end else begin
                            // This recessive bit is delimiter bit 1.
                            state_d      = OVL_DELIM;
                            cnt_load     = 1'b1;
                            cnt_load_val = CAN_CNT_W'(1);
                        end
                    end

                    OVL_DELIM: begin
                        if (canRX == CAN_RECESSIVE) begin
                            cnt_inc = 1'b1;
                            if (cnt_next == DELIM_LIM) begin
                                end_ovl_d = 1'b1;
                                // The endOverload bit counts as an
                                // intermission start for the next request.
                                armed_d   = 1'b1;
                                state_d   = OVL_IDLE;
                                cnt_clr   = 1'b1;
                            end
                        end else begin
                            form_err_d = 1'b1;
                            state_d    = OVL_IDLE;
                            cnt_clr    = 1'b1;
                        end
                    end

                    default: begin
                        state_d = OVL_IDLE;
                        cnt_clr = 1'b1;
                    end
                endcase
            end
        end

        // Transmit dominant only while sending our own flag.
        can_tx_d = (state_d == OVL_FLAG) ? CAN_DOMINANT : CAN_RECESSIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OVL_IDLE;
            can_tx_q   <= CAN_RECESSIVE;
            end_ovl_q  <= 1'b0;
            bit_err_q  <= 1'b0;
            form_err_q <= 1'b0;
            flag_err_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            can_tx_q   <= can_tx_d;
            end_ovl_q  <= end_ovl_d;
            bit_err_q  <= bit_err_d;
            form_err_q <= form_err_d;
            flag_err_q <= flag_err_d;
            armed_q    <= armed_d;
        end
    end

    assign canTX        = can_tx_q;
    assign overloadBusy = (state_q != OVL_IDLE);
    assign endOverload  = end_ovl_q;
    assign bitError     = bit_err_q;
    assign formError    = form_err_q;
    assign flagError    = flag_err_q;

endmodule

// File: tb/tb_overload_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_overload_frame_tx
// Scenario-driven bench. Each overload frame is described by its trigger,
// the number of superposed dominant bits and an optional fault; the
// expected output after every strobe is derived from the frame timeline
// and queued. A monitor pops and compares one entry per strobe.
// Output vector order: {canTX, overloadBusy, endOverload, bitError,
// formError, flagError}.
// ---------------------------------------------------------------------------
module tb_overload_frame_tx;
    import can_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic samplePoint = 1'b0;
    logic canRX = 1'b1;
    logic frameReady = 1'b0;
    logic isOverload = 1'b0;
    logic overloadRequest = 1'b0;
    logic canTX, overloadBusy, endOverload, bitError, formError, flagError;

    always #5 clk = ~clk;

    overload_frame_tx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .samplePoint     (samplePoint),
        .canRX           (canRX),
        .frameReady      (frameReady),
        .isOverload      (isOverload),
        .overloadRequest (overloadRequest),
        .canTX           (canTX),
        .overloadBusy    (overloadBusy),
        .endOverload     (endOverload),
        .bitError        (bitError),
        .formError       (formError),
        .flagError       (flagError)
    );

    localparam int FB = CAN_OVL_FLAG_BITS;
    localparam int DB = CAN_OVL_DELIM_BITS;
    localparam int XD = CAN_OVL_MAX_EXTRA_DOM;
    localparam int MR = CAN_MAX_REQ_OVERLOADS;

    logic [5:0] exp_v_q[$];
    string      exp_tag_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model session state
    int m_req   = 0;   // request-driven frames since last frameReady=0
    bit m_armed = 0;   // next frameReady=1 strobe is an intermission start

    logic [5:0] mon_v;
    string      mon_tag;

    function automatic logic [5:0] mk(input bit tx, input bit busy, input bit eov,
                                       input bit be, input bit fe, input bit fle);
        return {tx, busy, eov, be, fe, fle};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {canTX, overloadBusy, endOverload, bitError, formError, flagError};
    endfunction

    // Monitor: one comparison per strobe, plus a check that error pulses
    // are gone one clk later.
    initial begin
        forever begin
            @(posedge clk);
            if (samplePoint === 1'b1) begin
                #1;
                n_checks++;
                if (exp_v_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: actual=%b required=<none queued>", dut_vec());
                end else begin
                    mon_v   = exp_v_q.pop_front();
                    mon_tag = exp_tag_q.pop_front();
                    if (dut_vec() !== mon_v) begin
                        n_fail++;
                        $display("FAIL %s: actual {tx,busy,eov,bit,form,flag}=%b required=%b",
                                 mon_tag, dut_vec(), mon_v);
                    end
                end
                @(posedge clk);
                #1;
                n_checks++;
                if ({bitError, formError, flagError} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL pulse_width: actual errors=%b required=000",
                             {bitError, formError, flagError});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input bit fr, input bit ovl, input bit req, input bit rx,
                          input logic [5:0] ev, input string tag);
        @(negedge clk);
        frameReady      = fr;
        isOverload      = ovl;
        overloadRequest = req;
        canRX           = rx;
        samplePoint     = 1'b1;
        exp_v_q.push_back(ev);
        exp_tag_q.push_back(tag);
        @(negedge clk);
        samplePoint = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_strobe(input bit fr);
        bit ovl, req;
        ovl = fr ? 1'b0 : 1'($urandom_range(0, 1));
        req = fr ? 1'b0 : 1'($urandom_range(0, 1));
        if (!fr) begin
            m_req   = 0;
            m_armed = 1;
        end else begin
            m_armed = 0;
        end
        strobe(fr, ovl, req, 1'b1, mk(1, 0, 0, 0, 0, 0), "idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== mk(1, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_async: actual=%b required=%b", dut_vec(), mk(1, 0, 0, 0, 0, 0));
        end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_req   = 0;
        m_armed = 0;
    endtask

    // trig: 0 reactive, 1 request. fault: 0 none, 1 bit error at flag bit
    // fpos, 2 form error at delimiter bit fpos, 3 abort at strobe fpos,
    // 4 reset before flag strobe fpos.
    task automatic frame(input int trig, input int extra, input int fault, input int fpos);
        bit ovl, req, start, done, no, nr;
        int d;
        ovl = (trig == 0);
        req = (trig == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        start = ovl || (req && m_armed && (m_req < MR));
        if (!ovl && start) m_req++;
        m_armed = 0;
        $display("frame trig=%0d extra=%0d fault=%0d pos=%0d start=%0d req_count=%0d",
                 trig, extra, fault, fpos, start, m_req);
        if (!start) begin
            strobe(1, ovl, req, 1, mk(1, 0, 0, 0, 0, 0), "no_start");
            return;
        end
        strobe(1, ovl, req, 1, mk(0, 1, 0, 0, 0, 0), "flag_start");
        done = 0;
        for (int k = 1; k < 40 && !done; k++) begin
            no = 1'($urandom_range(0, 1));
            nr = 1'($urandom_range(0, 1));
            if (fault == 4 && k == fpos) begin
                do_reset();
                done = 1;
            end else if (fault == 3 && k == fpos) begin
                m_req   = 0;
                m_armed = 1;
                strobe(0, no, nr, 1, mk(1, 0, 0, 0, 0, 0), "abort");
                done = 1;
            end else if (k <= FB) begin
                if (fault == 1 && k == fpos) begin
                    strobe(1, no, nr, 1, mk(1, 0, 0, 1, 0, 0), "bit_error");
                    done = 1;
                end else begin
                    strobe(1, no, nr, 0, mk(k == FB, 1, 0, 0, 0, 0), "flag_bit");
                end
            end else if (k <= FB + extra) begin
                if (k - FB == XD) begin
                    strobe(1, no, nr, 0, mk(1, 0, 0, 0, 0, 1), "flag_error");
                    done = 1;
                end else begin
                    strobe(1, no, nr, 0, mk(1, 1, 0, 0, 0, 0), "superposed");
                end
            end else begin
                d = k - FB - extra;
                if (fault == 2 && d == fpos) begin
                    strobe(1, no, nr, 0, mk(1, 0, 0, 0, 1, 0), "form_error");
                    done = 1;
                end else if (d == DB) begin
                    m_armed = 1;
                    strobe(1, no, nr, 1, mk(1, 0, 1, 0, 0, 0), "delim_end");
                    done = 1;
                end else begin
                    strobe(1, no, nr, 1, mk(1, 1, 0, 0, 0, 0), "delim_bit");
                end
            end
        end
    endtask

    initial begin
        int fault, fpos, gaps;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec() !== mk(1, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_values: actual=%b required=%b", dut_vec(), mk(1, 0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        idle_strobe(0);
        frame(0, 0, 0, 0);          // plain reactive frame
        frame(0, 3, 0, 0);          // three superposed dominant bits
        idle_strobe(1);

        // Request limit: two back-to-back, third refused, cleared by frameReady=0
        idle_strobe(0);
        frame(1, 0, 0, 0);
        frame(1, 0, 0, 0);
        frame(1, 0, 0, 0);
        idle_strobe(0);
        frame(1, 0, 0, 0);

        frame(0, 0, 2, 4);          // dominant at delimiter bit 4
        frame(0, 7, 0, 0);          // flag error
        frame(0, 0, 1, 3);          // recessive readback at flag bit 3
        frame(0, 0, 4, 3);          // reset during flag bit 3
        idle_strobe(0);
        frame(0, 0, 3, 10);         // abort mid-delimiter

        for (int i = 0; i < 40; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) idle_strobe(1'($urandom_range(0, 3) != 0));
            fault = $urandom_range(0, 7);
            if (fault > 4) fault = 0;
            case (fault)
                1:       fpos = $urandom_range(1, FB);
                2:       fpos = $urandom_range(2, DB);
                3:       fpos = $urandom_range(1, 16);
                4:       fpos = $urandom_range(1, FB);
                default: fpos = 0;
            endcase
            frame($urandom_range(0, 1), $urandom_range(0, 8), fault, fpos);
        end

        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_v_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: actual=%0d entries required=0", exp_v_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/overload_frame_tx.md
# overload_frame_tx

Transmit-side companion to the CAN interframe-space monitor. It sends overload frames on `canTX`: 6 dominant flag bits, then waits out superposed flags, then 8 recessive delimiter bits. It also sends request-driven overload frames for a local receiver that is not ready. When the delimiter completes it returns `endOverload` to the monitor, so intermission tracking restarts at bit 2.

## Interface
Parameters:
- `FLAG_BITS`, 6: dominant bits in the overload flag.
- `DELIM_BITS`, 8: recessive bits in the delimiter. The first recessive bit counts.
- `MAX_EXTRA_DOM`, 7: dominant bits tolerated after our own flag before a flag error.
- `MAX_REQ_OVERLOADS`, 2: maximum consecutive request-driven overload frames.

Ports:
- `clk` input 1: system clock. All flops are on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `samplePoint` input 1: one-`clk` strobe at each bit sample point. The block acts only on these strobes.
- `canRX` input 1: bus level. 1 = recessive.
- `frameReady` input 1: 1 = previous frame's EOF complete (interframe space).
- `isOverload` input 1: reactive overload condition from the interframe monitor.
- `overloadRequest` input 1: level, local receiver requests delay.
- `canTX` output 1: transmit level. 1 = recessive. Registered.
- `overloadBusy` output 1: high from flag start until delimiter end or abort.
- `endOverload` output 1: delimiter complete. Held for exactly one bit; see Timing.
- `bitError` output 1: one-`clk` pulse.
- `formError` output 1: one-`clk` pulse.
- `flagError` output 1: one-`clk` pulse.

## Operation
States:
- IDLE
- FLAG: `cnt` counts own dominant bits.
- WAIT_REC: `cnt` counts extra dominant bits.
- DELIM: `cnt` counts recessive bits.

All transitions and counter updates happen only on `clk` edges with `samplePoint`=1.

IDLE:
- If `frameReady`=1 and `isOverload`=1: go to FLAG, `cnt`=0, `canTX`=0. This is a reactive start and does not change `reqCount`.
- Otherwise, if the strobe is intermission-start and `overloadRequest`=1 and `reqCount`<`MAX_REQ_OVERLOADS`: go to FLAG and increment `reqCount`.
- Intermission-start means the first strobe with `frameReady`=1 after either a strobe with `frameReady`=0 or our own `endOverload` bit.
- If both triggers occur on the same strobe, the reactive start wins and `reqCount` is unchanged.

FLAG, per strobe:
- `canRX`=0: `cnt`++. When `cnt` reaches `FLAG_BITS`, set `canTX`=1 and go to WAIT_REC with `cnt`=0.
- `canRX`=1 (readback mismatch): pulse `bitError`, set `canTX`=1, go to IDLE.

WAIT_REC, per strobe:
- `canRX`=0: `cnt`++. If `cnt` reaches `MAX_EXTRA_DOM`, pulse `flagError` and go to IDLE.
- `canRX`=1: go to DELIM with `cnt`=1.

DELIM, per strobe:
- `canRX`=1: `cnt`++. When `cnt` reaches `DELIM_BITS`, assert `endOverload` and go to IDLE.
- `canRX`=0: pulse `formError` and go to IDLE. No `endOverload`.

Common rules:
- `reqCount` clears on any strobe with `frameReady`=0.
- Any strobe with `frameReady`=0 while not in IDLE aborts: go to IDLE, `canTX`=1, no pulses.
- `overloadBusy` = (state != IDLE).
- `canTX`=1 in every state except FLAG.
- Counters are 4-bit and saturate; they never wrap.

## Timing
- Reset values: state=IDLE, `cnt`=0, `reqCount`=0, `canTX`=1, `overloadBusy`=0, `endOverload`=0, all error outputs 0. Reset applies immediately on `rst_n` falling, including mid-flag.
- Start latency: a trigger at strobe N drives `canTX`=0 from the `clk` after strobe N. Flag bits are sampled at strobes N+1 through N+6.
- `canTX` returns to 1 in the `clk` after strobe N+6.
- With no superposition, the delimiter spans strobes N+7 through N+14. `endOverload` rises in the `clk` after N+14 and falls in the `clk` after N+15. The monitor therefore sees it at exactly one strobe.
- Error pulses last exactly one `clk` and coincide with the state returning to IDLE.
- The earliest possible next start is at the strobe following the `endOverload` bit (strobe N+15).

## Structure
- Shared package `can_pkg`:
  - state enum `ovl_state_t`
  - constants `CAN_OVL_FLAG_BITS`, `CAN_OVL_DELIM_BITS`, `CAN_OVL_MAX_EXTRA_DOM`, `CAN_MAX_REQ_OVERLOADS`
  - `CAN_DOMINANT`=0, `CAN_RECESSIVE`=1
- One natural sub-module, `can_bit_counter`: strobe-enabled, saturating, with load/clear. It is shared with future error-frame logic.

## Test plan
- Reactive start: `frameReady`=1, `isOverload`=1 at strobe 0, bus loops back `canTX`. Required: `canTX`=0 for strobes 1–6, 1 from strobe 7; `endOverload` high between strobes 14 and 15; `overloadBusy` low after strobe 14.
- Superposition: bus held dominant for 3 strobes after our flag (strobes 7–9). Required: delimiter spans strobes 10–17; `endOverload` after strobe 17; no errors.
- Request limit: `overloadRequest` held 1 across intermissions. Required: exactly 2 frames back-to-back, none at the third intermission-start, `reqCount`=2. `frameReady`=0 for one strobe clears the count and the next request frame is sent.
- Errors:
  - Dominant at delimiter bit 4 → `formError` pulse, `canTX`=1, no `endOverload`.
  - 7 extra dominant bits → `flagError`.
  - Recessive readback at flag bit 3 → `bitError`.
- Reset and abort:
  - `rst_n`=0 at flag bit 3 → `canTX`=1 immediately, all outputs at reset values.
  - `frameReady`=0 mid-delimiter → IDLE, no pulses.
